// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - forwarding selects and load-use stall/bubble control
// Optional stall counter enabled by defining FWD_HAZARD_STALL_CNT_EN.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b10;
    localparam logic [1:0] SEL_WB  = 2'b01;

    // The M-stage load flag and the W stage drive no output (the register file
    // is write-before-read), so only the state that matters is kept.
    logic [REG_AW-1:0] x_rd_q, m_rd_q;
    logic              x_rw_q, x_mr_q, m_rw_q;
    logic [1:0]        fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
    logic              stall, kill;

    function automatic logic [1:0] pick_src(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] xrd, input logic xrw,
        input logic [REG_AW-1:0] mrd, input logic mrw
    );
        if (xrw && xrd != '0 && xrd == src)
            return SEL_MEM;
        else if (mrw && mrd != '0 && mrd == src)
            return SEL_WB;
        else
            return SEL_RF;
    endfunction

    always_comb begin
        stall = !reset && id_valid && !ex_flush && x_mr_q && (x_rd_q != '0) &&
                ((id_uses_rs && x_rd_q == id_rs) || (id_uses_rt && x_rd_q == id_rt));
        kill  = reset || stall || ex_flush || !id_valid;
        fwd_a_d = SEL_RF;
        fwd_b_d = SEL_RF;
        if (!kill) begin
            fwd_a_d = pick_src(id_rs, x_rd_q, x_rw_q, m_rd_q, m_rw_q);
            fwd_b_d = pick_src(id_rt, x_rd_q, x_rw_q, m_rd_q, m_rw_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_rd_q  <= '0;
            x_rw_q  <= 1'b0;
            x_mr_q  <= 1'b0;
            m_rd_q  <= '0;
            m_rw_q  <= 1'b0;
            fwd_a_q <= SEL_RF;
            fwd_b_q <= SEL_RF;
        end else begin
            m_rd_q  <= x_rd_q;
            m_rw_q  <= x_rw_q;
            x_rd_q  <= kill ? '0 : id_rd;
            x_rw_q  <= kill ? 1'b0 : id_regwrite;
            x_mr_q  <= kill ? 1'b0 : id_memread;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;
    assign pc_write    = !stall;
    assign ifid_write  = !stall;
    assign idex_bubble = kill;

`ifdef FWD_HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt_q <= '0;
        else if (stall && !(&stall_cnt_q))
            stall_cnt_q <= stall_cnt_q + 1'b1;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - scoreboard bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        id_uses_rs = 1'b0, id_uses_rt = 1'b0;
    logic        id_regwrite = 1'b0, id_memread = 1'b0, ex_flush = 1'b0;
    logic [1:0]  fwd_a, fwd_b;
    logic        pc_write, ifid_write, idex_bubble;
    logic [31:0] stall_cnt;

    fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .ex_flush(ex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_bubble(idex_bubble), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } ins_t;

    typedef struct {
        logic        pcw;
        logic        ifw;
        logic        bub;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] cnt;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   last_stall = 1'b0;
    exp_t sb[$];

    // Reference model: pipe[0] is the instruction now in EX, pipe[1] the one in MEM.
    ins_t        pipe[$];
    logic [1:0]  m_fa, m_fb;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        ins_t b;
        b.rd = '0; b.rw = 1'b0; b.mr = 1'b0;
        pipe.delete();
        pipe.push_back(b);
        pipe.push_back(b);
        m_fa = 2'b00;
        m_fb = 2'b00;
        m_cnt = '0;
    endfunction

    // Youngest in-flight writer of the register wins; distance picks the mux input.
    function automatic logic [1:0] src_sel(input logic [4:0] r);
        for (int i = 0; i < 2; i++)
            if (pipe[i].rw && pipe[i].rd != 0 && pipe[i].rd == r)
                return (i == 0) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic urs, input logic urt,
                        input logic rw, input logic mr, input logic fl);
        exp_t e;
        ins_t n;
        logic st, kl;
        @(posedge clk);
        #2;
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_uses_rs = urs; id_uses_rt = urt; id_regwrite = rw; id_memread = mr;
        ex_flush = fl;
        st = v && !fl && pipe[0].mr && pipe[0].rd != 0 &&
             ((urs && pipe[0].rd == rs) || (urt && pipe[0].rd == rt));
        kl = st || fl || !v;
        e.pcw = !st; e.ifw = !st; e.bub = kl;
        e.fa = m_fa; e.fb = m_fb; e.cnt = m_cnt;
        sb.push_back(e);
        m_fa = kl ? 2'b00 : src_sel(rs);
        m_fb = kl ? 2'b00 : src_sel(rt);
`ifdef FWD_HAZARD_STALL_CNT_EN
        if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
        n.rd = kl ? 5'd0 : rd;
        n.rw = kl ? 1'b0 : rw;
        n.mr = kl ? 1'b0 : mr;
        pipe.push_front(n);
        void'(pipe.pop_back());
        last_stall = st;
    endtask

    always @(negedge clk) begin
        if (mon_en && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("pc_write", {31'b0, pc_write}, {31'b0, e.pcw});
            chk("ifid_write", {31'b0, ifid_write}, {31'b0, e.ifw});
            chk("idex_bubble", {31'b0, idex_bubble}, {31'b0, e.bub});
            chk("fwd_a", {30'b0, fwd_a}, {30'b0, e.fa});
            chk("fwd_b", {30'b0, fwd_b}, {30'b0, e.fb});
            chk("stall_cnt", stall_cnt, e.cnt);
        end
    end

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic       v, urs, urt, rw, mr, fl;
        logic [4:0] rs, rt, rd;
        model_reset();
        #3;
        chk("rst_fwd_a", {30'b0, fwd_a}, 32'd0);
        chk("rst_fwd_b", {30'b0, fwd_b}, 32'd0);
        chk("rst_pc_write", {31'b0, pc_write}, 32'd1);
        chk("rst_idex_bubble", {31'b0, idex_bubble}, 32'd1);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        mon_en = 1'b1;

        // back-to-back ALU dependency
        step(1, 0, 0, 3, 0, 0, 1, 0, 0);
        step(1, 3, 7, 9, 1, 1, 1, 0, 0);
        idle();
        // distance-2 dependency, then younger rewrite takes priority
        step(1, 0, 0, 5, 0, 0, 1, 0, 0);
        step(1, 1, 2, 6, 1, 1, 1, 0, 0);
        step(1, 8, 5, 9, 1, 1, 1, 0, 0);
        step(1, 0, 0, 5, 0, 0, 1, 0, 0);
        step(1, 0, 0, 5, 0, 0, 1, 0, 0);
        step(1, 8, 5, 9, 1, 1, 1, 0, 0);
        idle();
        // load-use: stall once, then forward from MEM/WB
        step(1, 0, 0, 4, 0, 0, 1, 1, 0);
        step(1, 4, 2, 7, 1, 1, 1, 0, 0);
        step(1, 4, 2, 7, 1, 1, 1, 0, 0);
        idle();
        // register 0 never forwarded nor stalls
        step(1, 0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 6, 1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 6, 1, 1, 1, 0, 0);
        idle();
        // flush beats stall
        step(1, 0, 0, 4, 0, 0, 1, 1, 0);
        step(1, 4, 4, 7, 1, 1, 1, 0, 1);
        idle();
        idle();

        for (int i = 0; i < 400; i++) begin
            if (!last_stall) begin
                v = ($urandom_range(0, 99) < 85);
                rs = 5'($urandom_range(0, 3));
                rt = 5'($urandom_range(0, 3));
                rd = 5'($urandom_range(0, 3));
                urs = 1'($urandom);
                urt = 1'($urandom);
                rw = ($urandom_range(0, 99) < 75);
                mr = ($urandom_range(0, 99) < 30);
            end
            fl = ($urandom_range(0, 99) < 10);
            step(v, rs, rt, rd, urs, urt, rw, mr, fl);
        end
        idle();

        // asynchronous reset in the middle of a load-use stall
        step(1, 0, 0, 4, 0, 0, 1, 1, 0);
        step(1, 4, 0, 7, 1, 0, 1, 0, 0);
        #1;
        chk("pre_rst_stall", {31'b0, pc_write}, 32'd0);
        #1;
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("async_pc_write", {31'b0, pc_write}, 32'd1);
        chk("async_ifid_write", {31'b0, ifid_write}, 32'd1);
        chk("async_idex_bubble", {31'b0, idex_bubble}, 32'd1);
        chk("async_fwd_a", {30'b0, fwd_a}, 32'd0);
        chk("async_stall_cnt", stall_cnt, 32'd0);
        sb.delete();
        @(posedge clk);
        #2;
        id_valid = 1'b0;
        ex_flush = 1'b0;
        reset = 1'b0;
        model_reset();
        last_stall = 1'b0;
        mon_en = 1'b1;
        step(1, 4, 4, 7, 1, 1, 1, 0, 0);
        idle();
        idle();
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage pipeline.
- Tracks the destination-register and control bits of the instructions in EX, MEM and WB using internal shadow registers.
- Drives registered 2-bit selects for the two 32-bit 3-to-1 ALU-operand forwarding muxes.
- Detects load-use hazards and generates stall/bubble control for PC, IF/ID and ID/EX; honours a branch flush from EX.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 32, stall-counter width (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  REG_AW  source register A of the ID instruction.
- id_rt  in  REG_AW  source register B of the ID instruction.
- id_rd  in  REG_AW  destination of the ID instruction (after RegDst selection).
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_regwrite  in  1  ID instruction writes the register file.
- id_memread  in  1  ID instruction is a load.
- ex_flush  in  1  taken branch/jump resolved in EX; kill the instruction in ID.
- fwd_a  out  2  operand-A mux select, valid while the instruction is in EX.
- fwd_b  out  2  operand-B mux select, same timing.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID register enable.
- idex_bubble  out  1  load a NOP into ID/EX this cycle.
- stall_cnt  out  CNT_W  stall-cycle count.

Behaviour:
- Mux select encoding: 00 = ID/EX register-file value; 10 = EX/MEM ALU result; 01 = MEM/WB writeback value; 11 = never driven.
- Shadow stages, all updated on the same clock edge:
  - X (ID/EX): rd, regwrite, memread.
  - M (EX/MEM): rd, regwrite, memread.
  - W (MEM/WB): rd, regwrite.
- Each edge: W<=M, M<=X, X<= kill ? bubble : ID fields.
  - kill = stall | ex_flush | !id_valid.
  - bubble = regwrite 0, memread 0, rd 0.
- Stall (combinational): stall = id_valid & !ex_flush & X.memread & X.rd!=0 & ((id_uses_rs & X.rd==id_rs) | (id_uses_rt & X.rd==id_rt)).
- Stall/bubble outputs (combinational): pc_write = !stall; ifid_write = !stall; idex_bubble = kill.
- Forward selects are registered, one cycle of latency, so they line up with the instruction entering EX. Rule for fwd_a, applied at each edge:
  - kill → 00.
  - else X.regwrite & X.rd!=0 & X.rd==id_rs → 10.
  - else M.regwrite & M.rd!=0 & M.rd==id_rs → 01.
  - else 00.
- fwd_b uses the identical rule with id_rt.
- Priority: the younger producer (X, which becomes EX/MEM) beats the older one (M, which becomes MEM/WB).
- Register 0 is never forwarded and never causes a stall.
- id_uses_rs/id_uses_rt gate the stall only; forwarding a don't-care operand is harmless.
- Forwarding from W at ID time is not required: the register file is write-before-read.
- Load-use sequence:
  - Cycle N: stall=1; bubble enters X; fwd for the bubble = 00.
  - Cycle N+1: the consumer re-evaluates with the load now in M; the load is no longer in X, so stall=0 and select 01 is registered.
- Simultaneous ex_flush and stall: flush wins; stall=0, pc_write=1, bubble inserted.
- Reset (async): all shadow stages cleared; fwd_a=fwd_b=00; stall_cnt=0.
  - pc_write=ifid_write=1 and idex_bubble=1 (id_valid is ignored while reset is high; kill is forced).
  - Reset mid-stall drops the stall immediately.

Optional Feature:
- Macro: FWD_HAZARD_STALL_CNT_EN.
- Defined:
  - stall_cnt increments by 1 on each edge where stall=1.
  - Saturates at all-ones, no wrap.
  - Cleared only by reset.
- Undefined: counter logic is absent and stall_cnt is tied to 0. All other behaviour is identical.

Test Plan:
- Back-to-back ALU: add r3 (rd=3, regwrite) then sub reading rs=3 → next edge fwd_a=10, fwd_b=00, no stall.
- Distance-2 dependency: add r5; unrelated op; consumer with rt=5 → fwd_b=01 when the consumer is in EX; distance-1 re-write of r5 in between → fwd_b=10 (priority check).
- Load-use: lw r4 then add rs=4 → one cycle with stall=1, pc_write=0, ifid_write=0, idex_bubble=1; then fwd_a=01; with FWD_HAZARD_STALL_CNT_EN, stall_cnt=1.
- r0 guard: instruction writing rd=0 (regwrite=1), then consumer reading rs=0; separately lw to r0 then consumer of r0 → fwd_a=00 and stall=0 in both cases.
- Flush vs stall: load-use condition with ex_flush=1 in the same cycle → stall=0, pc_write=1, idex_bubble=1; next fwd_a=fwd_b=00.
- Async reset asserted mid-pipeline (mid-clock, during a stall) → outputs return to reset values immediately without a clock edge; shadow stages cleared, so a consumer of the pre-reset destination after release sees fwd=00.
